// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
package div_issue_ctrl_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DZ  = 2'b01;
    localparam logic [1:0] ERR_OVF = 2'b10;
    localparam logic [1:0] ERR_TO  = 2'b11;

endpackage

// File: rtl/div_timeout_cnt.sv
// Wait-state watchdog: counts while enabled, flags expiry on the last allowed cycle.
module div_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT > 1 ? TIMEOUT : 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/div_issue_ctrl.sv
// Operand screening, start/busy sequencing and result hand-off around the
// sign-magnitude fractional divider.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int W       = DIV_W,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_z,
    output logic [W-1:0] out_r,
    output logic [1:0]   out_err,
    output logic         div_start,
    output logic [W-1:0] div_x,
    output logic [W-1:0] div_y,
    input  logic [W-1:0] div_z,
    input  logic [W-1:0] div_r,
    input  logic         div_busy
);
    state_t state;
    logic   accept, sgn, tmr_en, tmr_clr, tmr_exp;

    assign accept = in_valid && in_ready;
    assign sgn    = in_x[W-1] ^ in_y[W-1];

    // Timer restarts on every state change, so both wait states get a full budget.
    assign tmr_en  = (state == S_WAIT_HI) || (state == S_WAIT_LO);
    assign tmr_clr = !tmr_en || (state == S_WAIT_HI && div_busy)
                             || (state == S_WAIT_LO && !div_busy);

    div_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            div_start <= 1'b0;
            out_z     <= '0;
            out_r     <= '0;
            out_err   <= ERR_OK;
            div_x     <= '0;
            div_y     <= '0;
        end else begin
            div_start <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    div_x    <= in_x;
                    div_y    <= in_y;
                    in_ready <= 1'b0;
                    if (in_y[W-2:0] == '0) begin
                        out_z     <= {sgn, {(W-1){1'b1}}};
                        out_r     <= '0;
                        out_err   <= ERR_DZ;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (in_x[W-2:0] >= in_y[W-2:0]) begin
                        out_z     <= {sgn, {(W-1){1'b1}}};
                        out_r     <= '0;
                        out_err   <= ERR_OVF;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        div_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT_HI;
                S_WAIT_HI: begin
                    if (div_busy) begin
                        state <= S_WAIT_LO;
                    end else if (tmr_exp) begin
                        out_z     <= '0;
                        out_r     <= '0;
                        out_err   <= ERR_TO;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_WAIT_LO: begin
                    // A finished divider wins over a same-cycle expiry.
                    if (!div_busy) begin
                        out_z     <= div_z;
                        out_r     <= div_r;
                        out_err   <= ERR_OK;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (tmr_exp) begin
                        out_z     <= '0;
                        out_r     <= '0;
                        out_err   <= ERR_TO;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
